// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the mem_controller CPU port. The winning request is
// latched, issued as a one-cycle rd/wr pulse, and completed back to its requester.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned WR_LAT     = 2,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_p0_req,
   input  logic                  i_p0_we,
   input  logic [ADDR_WIDTH-1:0] i_p0_addr,
   input  logic [DATA_WIDTH-1:0] i_p0_wdata,
   output logic                  o_p0_done,
   output logic [DATA_WIDTH-1:0] o_p0_rdata,
   input  logic                  i_p1_req,
   input  logic                  i_p1_we,
   input  logic [ADDR_WIDTH-1:0] i_p1_addr,
   input  logic [DATA_WIDTH-1:0] i_p1_wdata,
   output logic                  o_p1_done,
   output logic [DATA_WIDTH-1:0] o_p1_rdata,
   output logic                  o_mc_wr_req,
   output logic                  o_mc_rd_req,
   output logic [ADDR_WIDTH-1:0] o_mc_addr,
   output logic [DATA_WIDTH-1:0] o_mc_wdata,
   input  logic [DATA_WIDTH-1:0] i_mc_rdata,
   input  logic                  i_mc_rvalid,
   output logic                  o_busy
);

   typedef enum logic [2:0] {StIdle, StIssue, StWrWait, StRdWait, StResp} state_t;

   localparam logic [3:0] WrLatCnt = 4'(WR_LAT);

   state_t                r_state;
   state_t                w_state_d;
   logic                  r_we;
   logic                  r_winner;
   logic                  r_last_gnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [3:0]            r_cnt;
   logic                  w_any_req;
   logic                  w_winner;
   logic                  w_done;

   assign w_any_req = i_p0_req | i_p1_req;

   // A single requester always wins; a tie goes to port 0 or to the port not served last.
   always_comb begin
      w_winner = i_p1_req;
      if (i_p0_req && i_p1_req) begin
         w_winner = FIXED_PRIO ? 1'b0 : ~r_last_gnt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_we       <= 1'b0;
         r_winner   <= 1'b0;
         r_last_gnt <= 1'b1;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_state_d;
         case (r_state)
            StIdle: begin
               if (w_any_req) begin
                  r_winner <= w_winner;
                  r_we     <= w_winner ? i_p1_we    : i_p0_we;
                  r_addr   <= w_winner ? i_p1_addr  : i_p0_addr;
                  r_wdata  <= w_winner ? i_p1_wdata : i_p0_wdata;
               end
            end
            StIssue: begin
               r_last_gnt <= r_winner;
               r_cnt      <= WrLatCnt;
            end
            StWrWait: r_cnt <= r_cnt - 4'd1;
            StRdWait: begin
               if (i_mc_rvalid) begin
                  r_rdata <= i_mc_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_done      = 1'b0;
      o_mc_wr_req = 1'b0;
      o_mc_rd_req = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_any_req) begin
               w_state_d = StIssue;
            end
         end
         StIssue: begin
            o_mc_wr_req = r_we;
            o_mc_rd_req = ~r_we;
            w_state_d   = r_we ? StWrWait : StRdWait;
         end
         StWrWait: begin
            if (r_cnt <= 4'd1) begin
               w_done    = 1'b1;
               w_state_d = StIdle;
            end
         end
         StRdWait: begin
            if (i_mc_rvalid) begin
               w_state_d = StResp;
            end
         end
         StResp: begin
            w_done    = 1'b1;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign o_p0_done  = w_done & ~r_winner;
   assign o_p1_done  = w_done & r_winner;
   assign o_p0_rdata = (r_state == StResp && !r_winner) ? r_rdata : '0;
   assign o_p1_rdata = (r_state == StResp && r_winner) ? r_rdata : '0;
   assign o_mc_addr  = r_addr;
   assign o_mc_wdata = r_wdata;
   assign o_busy     = (r_state != StIdle);

endmodule
